// File: rtl/kyber_pkg.sv
// kyber_pkg -- shared Kyber constants and helpers for the sampling datapath.
//   KYBER_Q   : modulus; candidates below it are kept
//   KYBER_N   : coefficients per polynomial
//   COEF_W    : coefficient width
//   rej_state_t : control states of the rejection sampler
//   rej_candidate() : extracts one 12-bit candidate from a 3-byte group
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;

  localparam logic [COEF_W-1:0] KYBER_Q_C = COEF_W'(KYBER_Q);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } rej_state_t;

  // grp holds three stream bytes: b0 in [23:16], b1 in [15:8], b2 in [7:0].
  // Phase 0 yields b0 + 256*(b1 mod 16); phase 1 yields (b1 div 16) + 16*b2.
  function automatic logic [COEF_W-1:0] rej_candidate(input logic phase,
                                                      input logic [23:0] grp);
    if (!phase) return {grp[11:8], grp[23:16]};
    else        return {grp[7:0], grp[15:12]};
  endfunction

endpackage

// File: rtl/rej_bytebuf.sv
// rej_bytebuf -- 16-byte FIFO feeding the rejection sampler.
// Bytes are packed head-first in a 128-bit vector; unused tail bytes are
// always zero, so a push simply ORs the new word in at the fill position.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : synchronous flush (count and contents to zero)
//   push/push_data : append 8 bytes, stream byte 0 in [63:56]
//   pop            : drop the 3 head bytes
//   count          : bytes held, 0..16
//   head           : three head bytes, byte 0 in [23:16]
// The caller only pushes when count <= 8 and only pops when count >= 3.
module rej_bytebuf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic [4:0]  count,
  output logic [23:0] head
);

  logic [127:0] q;
  logic [127:0] q_nxt;
  logic [4:0]   base;
  logic [7:0]   sh;

  // Fill position is computed after any same-cycle pop.
  always_comb begin
    base  = count - (pop ? 5'd3 : 5'd0);
    sh    = {base, 3'b000};
    q_nxt = (pop ? (q << 24) : q) |
            (push ? ({push_data, 64'h0} >> sh) : 128'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      count <= '0;
    end else if (clear) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= q_nxt;
      count <= count + (push ? 5'd8 : 5'd0) - (pop ? 5'd3 : 5'd0);
    end
  end

  assign head = q[127:104];

endmodule

// File: rtl/rej_uniform.sv
// rej_uniform -- Kyber uniform rejection sampler (SampleNTT style).
// Consumes a 64-bit XOF byte stream, forms 12-bit candidates from each
// 3-byte group (two per group, one per cycle) and emits those below q
// with a running index until 256 have been produced.
// Ports:
//   i_clk, i_rstn          : clock, asynchronous active-low reset
//   i_start                : begin (or restart) a polynomial
//   i_ibytes/_valid        : stream word, byte 0 in [63:56]
//   o_ibytes_ready         : word taken when valid && ready
//   i_ibytes_done          : upstream has no more bytes for now
//   o_coef/_valid/_idx     : accepted coefficient, one-cycle valid, index
//   o_need_more            : pulse, stream ran out before 256 coefficients
//   o_done                 : pulse, one cycle after coefficient 255
// Optional build macro REJ_UNIFORM_STATS_EN adds o_rej_cnt, a saturating
// count of rejected candidates since the last i_start.
module rej_uniform import kyber_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [63:0]       i_ibytes,
  input  logic              i_ibytes_valid,
  output logic              o_ibytes_ready,
  input  logic              i_ibytes_done,
  output logic [COEF_W-1:0] o_coef,
  output logic              o_coef_valid,
  output logic [7:0]        o_coef_idx,
  output logic              o_need_more,
  output logic              o_done
`ifdef REJ_UNIFORM_STATS_EN
  ,
  output logic [9:0]        o_rej_cnt
`endif
);

  rej_state_t        state;
  logic              phase;
  logic [8:0]        acc;
  logic              pending;
  logic [4:0]        count;
  logic [23:0]       head;
  logic              push;
  logic              pop;
  logic              eval;
  logic              accept;
  logic              last;
  logic              clear;
  logic [COEF_W-1:0] cand;

  // Ready depends on registered state only, never on i_ibytes_valid.
  assign o_ibytes_ready = (state == S_RUN) && (count <= 5'd8);
  assign push   = i_ibytes_valid && o_ibytes_ready;
  // A restart pulse suppresses evaluation in its own cycle.
  assign eval   = (state == S_RUN) && (count >= 5'd3) && !i_start;
  assign pop    = eval && phase;
  assign cand   = rej_candidate(phase, head);
  assign accept = eval && (cand < KYBER_Q_C);
  assign last   = accept && (acc == 9'(KYBER_N - 1));
  // Leftover bytes are dropped once the polynomial is complete.
  assign clear  = i_start || (state == S_DONE);

  rej_bytebuf u_bytebuf (
    .clk       (i_clk),
    .rst_n     (i_rstn),
    .clear     (clear),
    .push      (push),
    .push_data (i_ibytes),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      acc          <= '0;
      pending      <= 1'b0;
      o_coef       <= '0;
      o_coef_valid <= 1'b0;
      o_coef_idx   <= '0;
      o_need_more  <= 1'b0;
      o_done       <= 1'b0;
`ifdef REJ_UNIFORM_STATS_EN
      o_rej_cnt    <= '0;
`endif
    end else begin
      o_coef_valid <= 1'b0;
      o_need_more  <= 1'b0;
      o_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_RUN;
            phase   <= 1'b0;
            acc     <= '0;
            pending <= 1'b0;
`ifdef REJ_UNIFORM_STATS_EN
            o_rej_cnt <= '0;
`endif
          end
        end
        S_RUN: begin
          if (i_start) begin
            phase   <= 1'b0;
            acc     <= '0;
            pending <= 1'b0;
`ifdef REJ_UNIFORM_STATS_EN
            o_rej_cnt <= '0;
`endif
          end else begin
            if (eval) begin
              phase <= ~phase;
              if (accept) begin
                o_coef       <= cand;
                o_coef_valid <= 1'b1;
                o_coef_idx   <= acc[7:0];
                acc          <= acc + 9'd1;
                if (last) state <= S_DONE;
              end
`ifdef REJ_UNIFORM_STATS_EN
              else if (o_rej_cnt != 10'h3FF) begin
                o_rej_cnt <= o_rej_cnt + 10'd1;
              end
`endif
            end
            // A done pulse arriving with the final word is judged only
            // after that word has been consumed down to a partial group.
            if (last) begin
              pending <= 1'b0;
            end else if (i_ibytes_done) begin
              if (push) begin
                pending <= 1'b1;
              end else begin
                o_need_more <= 1'b1;
                pending     <= 1'b0;
              end
            end else if (pending && (count < 5'd3)) begin
              o_need_more <= 1'b1;
              pending     <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          o_done  <= 1'b1;
          pending <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rej_uniform.sv
// tb_rej_uniform -- self-checking bench for rej_uniform.
// A byte-queue reference model turns every accepted stream word into the
// expected coefficient sequence; a monitor compares each emitted
// coefficient and index against it in order.
module tb_rej_uniform;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [63:0] i_ibytes;
  logic        i_ibytes_valid;
  logic        o_ibytes_ready;
  logic        i_ibytes_done;
  logic [11:0] o_coef;
  logic        o_coef_valid;
  logic [7:0]  o_coef_idx;
  logic        o_need_more;
  logic        o_done;
`ifdef REJ_UNIFORM_STATS_EN
  logic [9:0]  o_rej_cnt;
`endif

  rej_uniform dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_start        (i_start),
    .i_ibytes       (i_ibytes),
    .i_ibytes_valid (i_ibytes_valid),
    .o_ibytes_ready (o_ibytes_ready),
    .i_ibytes_done  (i_ibytes_done),
    .o_coef         (o_coef),
    .o_coef_valid   (o_coef_valid),
    .o_coef_idx     (o_coef_idx),
    .o_need_more    (o_need_more),
    .o_done         (o_done)
`ifdef REJ_UNIFORM_STATS_EN
    ,
    .o_rej_cnt      (o_rej_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] byte_q[$];
  int         exp_q[$];
  int         exp_idx, model_acc;
  int         done_cnt = 0, nm_cnt = 0;
  int         done_cyc = -1, nm_cyc = -1, idx255_cyc = -1, nm_qsize = -1;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    byte_q.delete();
    exp_q.delete();
    exp_idx   = 0;
    model_acc = 0;
  endfunction

  // Reference: take stream bytes three at a time, form both candidates,
  // keep those below q, stop after 256 kept.
  function automatic void model_push_word(input logic [63:0] w);
    int b0, b1, b2, d;
    for (int k = 0; k < 8; k++) byte_q.push_back(w[63-8*k -: 8]);
    while (byte_q.size() >= 3 && model_acc < 256) begin
      b0 = int'(byte_q.pop_front());
      b1 = int'(byte_q.pop_front());
      b2 = int'(byte_q.pop_front());
      d = b0 + 256 * (b1 % 16);
      if (d < 3329) begin exp_q.push_back(d); model_acc++; end
      if (model_acc < 256) begin
        d = b1 / 16 + 16 * b2;
        if (d < 3329) begin exp_q.push_back(d); model_acc++; end
      end
    end
  endfunction

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_coef_valid) begin
        if (exp_q.size() == 0) chk("coef_extra", 32'(o_coef), 4096);
        else begin
          chk("coef", 32'(o_coef), exp_q.pop_front());
          chk("idx", 32'(o_coef_idx), exp_idx);
        end
        if (o_coef_idx == 8'd255) idx255_cyc = cyc;
        exp_idx++;
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_need_more) begin nm_cnt++; nm_cyc = cyc; nm_qsize = exp_q.size(); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    i_ibytes_valid = 1'b0;
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic start_poly();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    model_reset();
  endtask

  task automatic send_word(input logic [63:0] w, input bit with_done);
    bit rdy;
    bit ok = 1'b0;
    i_ibytes = w;
    i_ibytes_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      rdy = o_ibytes_ready;
      i_ibytes_done = with_done && rdy;
      @(posedge i_clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    i_ibytes_done = 1'b0;
    if (ok) model_push_word(w);
    else chk("ready_timeout", 32'(ok), 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge i_clk); #1;
    end
    idle(4);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_ready"}, 32'(o_ibytes_ready), 0);
    chk({pfx, "_valid"}, 32'(o_coef_valid), 0);
    chk({pfx, "_coef"},  32'(o_coef), 0);
    chk({pfx, "_idx"},   32'(o_coef_idx), 0);
    chk({pfx, "_nm"},    32'(o_need_more), 0);
    chk({pfx, "_done"},  32'(o_done), 0);
  endtask

  initial begin
    int mc, d0, n0, kd, kh;
    bit mp, mpush, mev;
    i_rstn = 1'b0; i_start = 1'b0; i_ibytes = '0;
    i_ibytes_valid = 1'b0; i_ibytes_done = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk_outputs_zero("rst");
    i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // Directed groups: 01 0D 00 -> reject, 0; 00 0D 00 -> 3328, 0.
    start_poly();
    send_word(64'h010D00000D000000, 1'b0);
    idle(12);
    chk("dir_count", exp_idx, 3);
    chk("dir_left", exp_q.size(), 0);

    // Restart mid-run, then random words with random gaps.
    start_poly();
    for (int i = 0; i < 24; i++) begin
      send_word({$urandom, $urandom}, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    i_ibytes_valid = 1'b0;
    wait_drain("rand_drain");

    // All-FF stream: nothing accepted, ready follows the byte count.
    start_poly();
    mc = 0; mp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("ready_ff", 32'(o_ibytes_ready), 32'(mc <= 8));
      i_ibytes = 64'hFFFF_FFFF_FFFF_FFFF;
      i_ibytes_valid = 1'b1;
      mpush = (mc <= 8);
      mev = (mc >= 3);
      mc = mc + (mpush ? 8 : 0) - ((mev && mp) ? 3 : 0);
      if (mev) mp = ~mp;
      @(posedge i_clk); #1;
      if (mpush) model_push_word(i_ibytes);
    end
    idle(6);
    chk("ff_none", exp_idx, 0);

    // Zero stream to completion.
    start_poly();
    d0 = done_cnt;
    for (int i = 0; i < 48; i++) send_word(64'h0, 1'b0);
    i_ibytes_valid = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (done_cnt != d0) break;
      @(posedge i_clk); #1;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("done_count", exp_idx, 256);
    chk("done_timing", done_cyc, idx255_cyc + 1);
    chk("done_ready", 32'(o_ibytes_ready), 0);
    idle(3);
    chk("done_once", done_cnt - d0, 1);
    chk("idle_ready", 32'(o_ibytes_ready), 0);
    chk("done_left", exp_q.size(), 0);

    // Stream ends early: 63 FF words then one zero word, then done.
    start_poly();
    n0 = nm_cnt;
    for (int i = 0; i < 63; i++) send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_word(64'h0, 1'b0);
    idle(20);
    chk("nm_zeros", exp_idx, 4);
    chk("nm_early", nm_cnt - n0, 0);
    i_ibytes_done = 1'b1;
    @(posedge i_clk); #1;
    i_ibytes_done = 1'b0;
    kd = cyc;
    idle(3);
    chk("nm_pulse", nm_cnt - n0, 1);
    chk("nm_timing", nm_cyc, kd);
    send_word(64'h0, 1'b0);
    send_word({$urandom, $urandom}, 1'b0);
    i_ibytes_valid = 1'b0;
    wait_drain("resume_drain");
    chk("resume_cnt", 32'(exp_idx >= 10), 1);

    // Done coincident with the final word: judged after the buffer drains.
    n0 = nm_cnt;
    send_word(64'h0, 1'b1);
    kh = cyc;
    i_ibytes_valid = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (nm_cnt != n0) break;
      @(posedge i_clk); #1;
    end
    chk("nm_coinc", nm_cnt - n0, 1);
    chk("nm_coinc_drained", nm_qsize, 0);
    chk("nm_coinc_late", 32'(nm_cyc > kh + 1), 1);

    // Reset in the middle of a polynomial.
    start_poly();
    for (int i = 0; i < 200; i++) begin
      if (exp_idx >= 100) break;
      send_word({$urandom, $urandom}, 1'b0);
    end
    chk("pre_rst_cnt", 32'(exp_idx >= 100), 1);
    i_rstn = 1'b0;
    i_ibytes_valid = 1'b0;
    @(posedge i_clk); #1;
    chk_outputs_zero("midrst");
    model_reset();
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    start_poly();
    send_word(64'h0, 1'b0);
    send_word(64'h0, 1'b0);
    i_ibytes_valid = 1'b0;
    wait_drain("post_rst_drain");
    chk("post_rst_cnt", exp_idx, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rej_uniform.md
REJ_UNIFORM -- requirements
Module: rej_uniform

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port i_rstn, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port i_start, input, 1, one-cycle pulse that begins a new polynomial.
REQ-004 SHALL have port i_ibytes, input, 64, XOF byte stream word; stream byte 0 in [63:56], byte 7 in [7:0].
REQ-005 SHALL have port i_ibytes_valid, input, 1, i_ibytes valid.
REQ-006 SHALL have port o_ibytes_ready, output, 1, word accepted when valid&&ready.
REQ-007 SHALL have port i_ibytes_done, input, 1, upstream squeeze finished pulse.
REQ-008 SHALL have port o_coef, output, 12, accepted coefficient.
REQ-009 SHALL have port o_coef_valid, output, 1, o_coef valid for one cycle.
REQ-010 SHALL have port o_coef_idx, output, 8, coefficient index 0..255.
REQ-011 SHALL have port o_need_more, output, 1, pulse: stream ended before 256 coefficients.
REQ-012 SHALL have port o_done, output, 1, pulse: 256th coefficient emitted.

Function
REQ-013 SHALL use states S_IDLE, S_RUN, S_DONE; IDLE->RUN on i_start; RUN->DONE when 256th coefficient is accepted; DONE->IDLE after one cycle.
REQ-014 SHALL hold a 16-byte FIFO buffer with 5-bit byte count; o_ibytes_ready = (state==S_RUN) && (count<=8), registered-state based only.
REQ-015 SHALL push 8 bytes on handshake, same-cycle push and pop allowed: count_next = count + 8*push - 3*pop.
REQ-016 SHALL evaluate one candidate per cycle when count>=3: phase 0 d1 = b0 + 256*(b1 mod 16); phase 1 d2 = (b1 div 16) + 16*b2, then pop 3 bytes.
REQ-017 SHALL accept candidate iff d < 3329; rejected candidates produce no output.
REQ-018 SHALL register outputs: o_coef/o_coef_valid/o_coef_idx one cycle after evaluation; idx increments per accepted coefficient.
REQ-019 SHALL stop evaluating after 256 accepts; remaining buffered bytes discarded; o_done asserted in S_DONE.
REQ-020 SHALL, on i_ibytes_done in S_RUN with fewer than 256 accepts, pulse o_need_more next cycle and remain in S_RUN retaining buffer, phase and count.
REQ-021 SHALL, if i_ibytes_done coincides with the final word handshake, accept the word before judging need-more after buffer drains below 3 bytes.
REQ-022 SHALL treat i_start in S_RUN as restart: clear buffer, phase, count, idx.
REQ-023 SHALL ignore i_ibytes_valid outside S_RUN (ready low).

Reset
REQ-024 SHALL on i_rstn low clear state to S_IDLE, buffer, count, phase, idx; all outputs 0, including mid-operation.

Configuration
REQ-025 SHALL with REJ_UNIFORM_STATS_EN defined add output o_rej_cnt (10 bits) counting rejected candidates since i_start, saturating at 1023; without it, port and counter absent, behaviour otherwise identical.

Structure
REQ-026 SHALL take KYBER_Q=3329, KYBER_N=256, coefficient width 12 from shared package kyber_pkg.
REQ-027 SHALL place the byte FIFO in one sub-module rej_bytebuf; comparator/FSM stay in rej_uniform.

Verification
REQ-028 Bytes 01 0D 00 -> d1=3329 rejected, d2=0 emitted with idx 0.
REQ-029 Bytes 00 0D 00 -> 3328 then 0 emitted, idx 0 and 1.
REQ-030 Bytes FF FF FF repeated -> no o_coef_valid, o_ibytes_ready toggles by count rule.
REQ-031 Continuous valid all-zero words -> 256 zeros, idx 0..255, o_done one cycle after idx 255, ready low thereafter.
REQ-032 i_ibytes_done after 63 words of FF then 1 word 00 -> o_need_more pulse, further words resume output.
REQ-033 i_rstn low after 100 coefficients -> all outputs 0 next edge; new i_start restarts idx at 0.
